// File: rtl/resp_formatter.sv
// resp_formatter
//   Turns a result word (or an error flag) into one ASCII hex text line and
//   hands it to the UART transmit port one byte at a time.
//   Normal line : ["0x"] + DATA_WIDTH/4 hex digits (MSB first) + [CR] LF
//   Error line  : "ERR" + [CR] LF
// Ports
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   req_i                 start pulse, accepted only in IDLE
//   req_err_i             with req_i: send "ERR" instead of the word
//   req_data_i            result word, latched with req_i
//   busy_o                high while a line is in progress
//   done_o                one-cycle pulse after the last byte strobe
//   tx_irq_o, tx_data_o   byte strobe and byte towards uart_if
//   tx_busy_i             uart_if busy; strobes wait while it is high
module resp_formatter #(
  parameter int DATA_WIDTH = 32,
  parameter int PREFIX_EN  = 1,
  parameter int UPPER_CASE = 1,
  parameter int EOL_CRLF   = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  req_err_i,
  input  logic [DATA_WIDTH-1:0] req_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  tx_irq_o,
  output logic [7:0]            tx_data_o,
  input  logic                  tx_busy_i
);

  localparam int NDIG     = DATA_WIDTH / 4;
  localparam int PFX_LEN  = 2 * PREFIX_EN;
  localparam int EOL_LEN  = 1 + EOL_CRLF;
  localparam int NORM_LEN = PFX_LEN + NDIG + EOL_LEN;
  localparam int ERR_LEN  = 3 + EOL_LEN;
  localparam int MAX_LEN  = (NORM_LEN > ERR_LEN) ? NORM_LEN : ERR_LEN;
  localparam int IDX_W    = $clog2(MAX_LEN + 1);

  localparam logic [IDX_W-1:0] C_ONE      = IDX_W'(1);
  localparam logic [IDX_W-1:0] C_TWO      = IDX_W'(2);
  localparam logic [IDX_W-1:0] C_THREE    = IDX_W'(3);
  localparam logic [IDX_W-1:0] C_DIG_END  = IDX_W'(PFX_LEN + NDIG);
  localparam logic [IDX_W-1:0] C_NORM_LST = IDX_W'(NORM_LEN - 1);
  localparam logic [IDX_W-1:0] C_ERR_LST  = IDX_W'(ERR_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT, S_SEND, S_HOLD, S_DONE
  } state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_index;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_err;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_irq;
  logic [7:0]            r_data;

  logic [3:0]            w_nibble;
  logic                  w_in_prefix;
  logic                  w_is_digit;
  logic [IDX_W-1:0]      w_last;
  logic [7:0]            w_byte;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    logic [7:0] base;
    base = (UPPER_CASE != 0) ? 8'h41 : 8'h61;
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return base + {4'h0, n} - 8'd10;
  endfunction

  // The digit to send is always the top nibble; the word is shifted left
  // after each digit byte so no variable part-select is needed.
  assign w_nibble    = r_shift[DATA_WIDTH-1 -: 4];
  assign w_in_prefix = (PREFIX_EN != 0) && (r_index < C_TWO);
  assign w_is_digit  = !r_err && !w_in_prefix && (r_index < C_DIG_END);
  assign w_last      = r_err ? C_ERR_LST : C_NORM_LST;

  always_comb begin
    w_byte = 8'h0A;
    if (r_err) begin
      if (r_index < C_THREE)
        w_byte = (r_index == '0) ? 8'h45 : 8'h52;
      else if ((EOL_CRLF != 0) && (r_index == C_THREE))
        w_byte = 8'h0D;
    end else begin
      if (w_in_prefix)
        w_byte = (r_index == C_ONE) ? 8'h78 : 8'h30;
      else if (r_index < C_DIG_END)
        w_byte = hex_ascii(w_nibble);
      else if ((EOL_CRLF != 0) && (r_index == C_DIG_END))
        w_byte = 8'h0D;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_index <= '0;
      r_shift <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_irq   <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (req_i) begin
            r_shift <= req_data_i;
            r_err   <= req_err_i;
            r_index <= '0;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_data  <= w_byte;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (!tx_busy_i) begin
            r_irq   <= 1'b1;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          r_irq   <= 1'b0;
          r_state <= S_HOLD;
        end
        // Dead cycle so uart_if has time to raise tx_busy before the next WAIT.
        S_HOLD: begin
          if (r_index == w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            if (w_is_digit) r_shift <= r_shift << 4;
            r_index <= r_index + C_ONE;
            r_state <= S_LOAD;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign tx_irq_o  = r_irq;
  assign tx_data_o = r_data;

endmodule

// File: tb/tb_resp_formatter.sv
module tb_resp_formatter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, req_err;
  logic [31:0] req_data;
  logic        busy, done, irq;
  logic [7:0]  txd;
  logic        tx_busy = 1'b0;

  logic        req2, err2;
  logic [15:0] data2;
  logic        busy2, done2, irq2;
  logic [7:0]  txd2;
  logic        txb2 = 1'b0;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done2_cnt = 0;
  int          viol = 0;
  int          busy_left = 0;
  bit          model_en = 1'b0;
  bit          busy_drop = 1'b0;
  logic [7:0]  cap_q[$];
  int          cap_t[$];
  logic [7:0]  cap2_q[$];
  logic [7:0]  exp_q[$];

  localparam int BUSY_N = 1000;

  resp_formatter dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_err_i(req_err),
    .req_data_i(req_data), .busy_o(busy), .done_o(done),
    .tx_irq_o(irq), .tx_data_o(txd), .tx_busy_i(tx_busy)
  );

  resp_formatter #(.DATA_WIDTH(16), .PREFIX_EN(0), .UPPER_CASE(0), .EOL_CRLF(0)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req2), .req_err_i(err2),
    .req_data_i(data2), .busy_o(busy2), .done_o(done2),
    .tx_irq_o(irq2), .tx_data_o(txd2), .tx_busy_i(txb2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Capture strobes and done pulses; model uart_if busy when enabled.
  always @(negedge clk) begin
    if (irq === 1'b1) begin
      cap_q.push_back(txd);
      cap_t.push_back(cyc);
      if (tx_busy) viol++;
    end
    if (done === 1'b1) done_cnt++;
    if (irq2 === 1'b1) cap2_q.push_back(txd2);
    if (done2 === 1'b1) done2_cnt++;
    if (!model_en) begin
      tx_busy   = 1'b0;
      busy_left = 0;
    end else if (irq === 1'b1) begin
      tx_busy   = 1'b1;
      busy_left = BUSY_N;
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) tx_busy = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input bit sel, input int prev, input int budget);
    int k = 0;
    busy_drop = 1'b0;
    while (((sel ? done2_cnt : done_cnt) == prev) && (k < budget)) begin
      step();
      k++;
      if (!sel && (done_cnt == prev) && (busy !== 1'b1)) busy_drop = 1'b1;
    end
    chk({tag, "_done_seen"}, ((sel ? done2_cnt : done_cnt) == prev + 1), 1);
  endtask

  task automatic check_line(input string tag, input bit sel);
    int n;
    n = sel ? cap2_q.size() : cap_q.size();
    chk({tag, "_count"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < n) chk($sformatf("%s_byte%0d", tag, i), sel ? cap2_q[i] : cap_q[i], exp_q[i]);
    $display("%s line done: %0d bytes", tag, n);
  endtask

  task automatic start(input logic err, input logic [31:0] d);
    req = 1'b1; req_err = err; req_data = d;
    cap_q.delete(); cap_t.delete();
  endtask

  initial begin
    int c0, prev, n0;
    rst_n = 1'b0; req = 1'b0; req_err = 1'b0; req_data = '0;
    req2 = 1'b0; err2 = 1'b0; data2 = '0;
    step(); step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_irq", irq, 0);
    chk("rst_txd", txd, 8'h00);
    chk("rst_txd2", txd2, 8'h00);
    rst_n = 1'b1;
    step();

    // T1: default line
    exp_q = '{8'h30, 8'h78, 8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
    prev = done_cnt;
    start(1'b0, 32'h1234ABCD); c0 = cyc;
    step(); req = 1'b0; req_data = 32'h0;
    chk("T1_busy_accept", busy, 1);
    wait_done("T1", 1'b0, prev, 500);
    chk("T1_done_pulse", done, 1);
    chk("T1_busy_at_done", busy, 0);
    check_line("T1", 1'b0);
    if (cap_t.size() >= 2) begin
      chk("T1_first_latency", cap_t[0] - c0, 3);
      chk("T1_byte_spacing", cap_t[1] - cap_t[0], 4);
    end
    step(); step();
    chk("T1_done_one_clk", done, 0);
    chk("T1_txd_hold", txd, 8'h0A);
    chk("T1_one_done", done_cnt, prev + 1);

    // T2: 16-bit lower case, no prefix, LF only
    exp_q = '{8'h30, 8'h30, 8'h66, 8'h65, 8'h0A};
    prev = done2_cnt; cap2_q.delete();
    req2 = 1'b1; data2 = 16'h00fe;
    step(); req2 = 1'b0; data2 = 16'h0;
    wait_done("T2", 1'b1, prev, 300);
    check_line("T2", 1'b1);
    step();

    // T3: error line, data ignored
    exp_q = '{8'h45, 8'h52, 8'h52, 8'h0D, 8'h0A};
    prev = done_cnt;
    start(1'b1, 32'hFFFFFFFF);
    step(); req = 1'b0; req_err = 1'b0;
    wait_done("T3", 1'b0, prev, 300);
    check_line("T3", 1'b0);
    step();

    // T4: uart_if busy for 1000 clk after every strobe
    exp_q = '{8'h30, 8'h78, 8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
    model_en = 1'b1; viol = 0;
    prev = done_cnt;
    start(1'b0, 32'h1234ABCD);
    step(); req = 1'b0;
    wait_done("T4", 1'b0, prev, 20000);
    check_line("T4", 1'b0);
    chk("T4_no_strobe_while_busy", viol, 0);
    if (cap_t.size() >= 2) chk("T4_gap_ge_busy", (cap_t[1] - cap_t[0]) >= BUSY_N, 1);
    model_en = 1'b0;
    step(); step();

    // T5: second request pulsed at byte 5 is ignored
    prev = done_cnt;
    start(1'b0, 32'h1234ABCD);
    step(); req = 1'b0;
    n0 = 0;
    while (cap_q.size() < 5 && n0 < 300) begin step(); n0++; end
    req = 1'b1; req_data = 32'h0;
    step(); req = 1'b0;
    if (busy !== 1'b1) busy_drop = 1'b1;
    begin
      bit early_drop;
      early_drop = busy_drop;
      wait_done("T5", 1'b0, prev, 500);
      chk("T5_busy_held", early_drop | busy_drop, 0);
    end
    check_line("T5", 1'b0);
    step(); step(); step();
    chk("T5_no_extra_line", done_cnt, prev + 1);

    // T6: reset after the 6th strobe
    prev = done_cnt;
    start(1'b0, 32'h1234ABCD);
    step(); req = 1'b0;
    n0 = 0;
    while (cap_q.size() < 6 && n0 < 300) begin step(); n0++; end
    chk("T6_reached_6", cap_q.size(), 6);
    rst_n = 1'b0;
    step(); step();
    chk("T6_rst_busy", busy, 0);
    chk("T6_rst_done", done, 0);
    chk("T6_rst_irq", irq, 0);
    chk("T6_rst_txd", txd, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) step();
    chk("T6_no_more_strobes", cap_q.size(), 6);
    chk("T6_no_done", done_cnt, prev);
    start(1'b0, 32'h1234ABCD);
    step(); req = 1'b0;
    wait_done("T6", 1'b0, prev, 500);
    check_line("T6", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
